// File: rtl/tlb_arbiter_pkg.sv
// ============================================================================
// Module      : tlb_arbiter_pkg
// Description : Shared TLB request type and grant-select encodings used by the
//               TLB arbiter and its Random counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlb_arbiter_pkg;

  // Operation driven to the TLB; NO_REQ covers idle and plain lookups.
  typedef enum logic [2:0] {
    NO_REQ = 3'd0,
    TLBR   = 3'd1,
    TLBWI  = 3'd2,
    TLBWR  = 3'd3,
    TLBP   = 3'd4
  } tlb_req_t;

  // Grant select encodings; they double as the arbiter state encoding.
  localparam logic [1:0] c_SEL_NONE = 2'b00;
  localparam logic [1:0] c_SEL_INST = 2'b01;
  localparam logic [1:0] c_SEL_DATA = 2'b10;
  localparam logic [1:0] c_SEL_OP   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/tlb_arbiter_random.sv
// ============================================================================
// Module      : tlb_random
// Description : CP0 Random register. Counts down every cycle, can be held
//               and reloaded to TLBEntries-1, and wraps to TLBEntries-1.
//               Build option TLB_WIRED_EN: wrap point is the Wired register
//               instead of 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_random
  import tlb_arbiter_pkg::*;
#(
  parameter int TLBEntries = 32,
  localparam int c_IDX_W = $clog2(TLBEntries)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_hold,
  input  logic               i_reload,
`ifdef TLB_WIRED_EN
  input  logic [c_IDX_W-1:0] i_wired,
`endif
  output logic [c_IDX_W-1:0] o_random
);

  localparam logic [c_IDX_W-1:0] c_MAX = c_IDX_W'(TLBEntries - 1);

  logic [c_IDX_W-1:0] r_random;
  logic [c_IDX_W-1:0] w_next;

  // Next Random value: reload beats hold, hold beats the countdown.
  always_comb begin
    w_next = r_random - 1'b1;
    if (i_reload) begin
      w_next = c_MAX;
    end else if (i_hold) begin
      w_next = r_random;
    end else begin
`ifdef TLB_WIRED_EN
      // A Wired value past the last entry leaves no random range at all.
      if (int'(i_wired) >= TLBEntries) begin
        w_next = c_MAX;
      end else if (r_random <= i_wired) begin
        w_next = c_MAX;
      end
`else
      if (r_random == '0) begin
        w_next = c_MAX;
      end
`endif
    end
  end

  // Random register with synchronous active-low reset to the top entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_random <= c_MAX;
    end else begin
      r_random <= w_next;
    end
  end

  assign o_random = r_random;

endmodule

`default_nettype wire

// File: rtl/tlb_arbiter.sv
// ============================================================================
// Module      : tlb_arbiter
// Description : Arbitrates the shared TLB between instruction lookups, data
//               lookups and CP0 TLB instructions. CP0 ops win in IDLE; inst
//               and data share round-robin. Build option TLB_WIRED_EN adds
//               the Wired input that bounds the Random counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_arbiter
  import tlb_arbiter_pkg::*;
#(
  parameter int TLBEntries = 32,
  localparam int c_IDX_W = $clog2(TLBEntries)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               inst_req,
  output logic               inst_done,
  input  logic               data_req,
  output logic               data_done,
  input  logic               op_req,
  input  tlb_req_t           op_type,
  input  logic [c_IDX_W-1:0] op_index,
  output logic               op_done,
  output tlb_req_t           tlb_req,
  output logic [c_IDX_W-1:0] tlb_index,
  output logic [1:0]         tlb_sel,
  input  logic               tlb_ok,
  output logic [c_IDX_W-1:0] random
`ifdef TLB_WIRED_EN
  ,
  input  logic [c_IDX_W-1:0] wired
`endif
);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               r_last_data;   // 0: inst served last, 1: data served last
  tlb_req_t           r_tlb_req;
  logic [c_IDX_W-1:0] r_tlb_index;
  logic               r_inst_done;
  logic               r_data_done;
  logic               r_op_done;
  logic               w_inst_v;
  logic               w_data_v;
  logic               w_op_v;
  logic               w_fin_i;
  logic               w_fin_d;
  logic               w_fin_op;
  logic               w_enter_op;
  logic               w_hold;
  logic               w_reload;
  logic [c_IDX_W-1:0] w_random;

  // Requesters still hold their request during their done cycle; ignore it
  // there so a finished access is not granted a second time.
  assign w_inst_v = inst_req & ~r_inst_done;
  assign w_data_v = data_req & ~r_data_done;
  assign w_op_v   = op_req   & ~r_op_done;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_SEL_NONE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: grant from IDLE, release on completion or withdrawal.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_SEL_NONE: begin
        if (w_op_v) begin
          w_next = c_SEL_OP;
        end else if (w_inst_v && w_data_v) begin
          w_next = r_last_data ? c_SEL_INST : c_SEL_DATA;
        end else if (w_data_v) begin
          w_next = c_SEL_DATA;
        end else if (w_inst_v) begin
          w_next = c_SEL_INST;
        end
      end
      c_SEL_INST: if (!inst_req || tlb_ok) w_next = c_SEL_NONE;
      c_SEL_DATA: if (!data_req || tlb_ok) w_next = c_SEL_NONE;
      c_SEL_OP:   if (!op_req   || tlb_ok) w_next = c_SEL_NONE;
      default:    w_next = c_SEL_NONE;
    endcase
  end

  // Output decode: grant select and completion/Random control strobes.
  always_comb begin
    tlb_sel    = r_state;
    w_fin_i    = (r_state == c_SEL_INST) && inst_req && tlb_ok;
    w_fin_d    = (r_state == c_SEL_DATA) && data_req && tlb_ok;
    w_fin_op   = (r_state == c_SEL_OP)   && op_req   && tlb_ok;
    w_enter_op = (r_state == c_SEL_NONE) && (w_next == c_SEL_OP);
    w_reload   = w_fin_op && ((r_tlb_req == TLBWI) || (r_tlb_req == TLBWR));
    // Freeze Random from the grant edge so the latched index matches it.
    w_hold     = ((r_state == c_SEL_OP) && (r_tlb_req == TLBWR)) ||
                 (w_enter_op && (op_type == TLBWR));
  end

  // Registered TLB command, done pulses and round-robin history.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tlb_req   <= NO_REQ;
      r_tlb_index <= '0;
      r_inst_done <= 1'b0;
      r_data_done <= 1'b0;
      r_op_done   <= 1'b0;
      r_last_data <= 1'b0;
    end else begin
      r_inst_done <= w_fin_i;
      r_data_done <= w_fin_d;
      r_op_done   <= w_fin_op;
      if (w_enter_op) begin
        r_tlb_req   <= op_type;
        r_tlb_index <= (op_type == TLBWR) ? w_random : op_index;
      end else if (w_next != c_SEL_OP) begin
        r_tlb_req <= NO_REQ;
      end
      if ((r_state == c_SEL_NONE) && (w_next == c_SEL_INST)) begin
        r_last_data <= 1'b0;
      end else if ((r_state == c_SEL_NONE) && (w_next == c_SEL_DATA)) begin
        r_last_data <= 1'b1;
      end
    end
  end

  tlb_random #(
    .TLBEntries (TLBEntries)
  ) u_random (
    .clk      (clk),
    .resetn   (resetn),
    .i_hold   (w_hold),
    .i_reload (w_reload),
`ifdef TLB_WIRED_EN
    .i_wired  (wired),
`endif
    .o_random (w_random)
  );

  assign tlb_req   = r_tlb_req;
  assign tlb_index = r_tlb_index;
  assign inst_done = r_inst_done;
  assign data_done = r_data_done;
  assign op_done   = r_op_done;
  assign random    = w_random;

endmodule

`default_nettype wire

// File: tb/tb_tlb_arbiter.sv
// ============================================================================
// Module      : tb_tlb_arbiter
// Description : Self-checking bench for tlb_arbiter: per-cycle vector table
//               plus hand-written Random, TLBWR and Wired sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_arbiter;
  import tlb_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       inst_req = 1'b0, data_req = 1'b0, op_req = 1'b0, tlb_ok = 1'b0;
  tlb_req_t   op_type = NO_REQ;
  logic [4:0] op_index = '0;
  logic       inst_done, data_done, op_done;
  tlb_req_t   tlb_req;
  logic [4:0] tlb_index, random;
  logic [1:0] tlb_sel;
`ifdef TLB_WIRED_EN
  logic [4:0] wired = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tlb_arbiter #(.TLBEntries(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst_req  (inst_req),
    .inst_done (inst_done),
    .data_req  (data_req),
    .data_done (data_done),
    .op_req    (op_req),
    .op_type   (op_type),
    .op_index  (op_index),
    .op_done   (op_done),
    .tlb_req   (tlb_req),
    .tlb_index (tlb_index),
    .tlb_sel   (tlb_sel),
    .tlb_ok    (tlb_ok),
    .random    (random)
`ifdef TLB_WIRED_EN
    ,
    .wired     (wired)
`endif
  );

  typedef struct {
    logic       rn, ir, dr, orq;
    tlb_req_t   ot;
    logic [4:0] oi;
    logic       ok;
    logic [1:0] es;
    tlb_req_t   er;
    int         ei;      // -1: index not checked
    logic       eid, edd, eod;
    int         erand;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rn, ir, dr, orq, input tlb_req_t ot,
                     input logic [4:0] oi, input logic ok, input logic [1:0] es,
                     input tlb_req_t er, input int ei,
                     input logic eid, edd, eod, input int erand);
    vq.push_back('{rn, ir, dr, orq, ot, oi, ok, es, er, ei, eid, edd, eod, erand});
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic rn, ir, dr, orq, input tlb_req_t ot,
                      input logic [4:0] oi, input logic ok);
    @(negedge clk);
    resetn = rn; inst_req = ir; data_req = dr; op_req = orq;
    op_type = ot; op_index = oi; tlb_ok = ok;
    @(posedge clk);
    #1;
    check("one_done", 32'($countones({inst_done, data_done, op_done}) <= 1), 32'd1);
  endtask

  task automatic idle(input logic rn);
    step(rn, 0, 0, 0, NO_REQ, 5'd0, 0);
  endtask

  int exp_r;

  initial begin
    // ---------------- vector table ----------------
    // Round-robin: both request continuously, tlb_ok in every grant cycle.
    add(0,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ, 0, 0,0,0, 31);
    add(1,1,1,0,NO_REQ,0,0, c_SEL_DATA,NO_REQ,-1, 0,0,0, 30);
    add(1,1,1,0,NO_REQ,0,1, c_SEL_NONE,NO_REQ,-1, 0,1,0, 29);
    add(1,1,1,0,NO_REQ,0,0, c_SEL_INST,NO_REQ,-1, 0,0,0, 28);
    add(1,1,1,0,NO_REQ,0,1, c_SEL_NONE,NO_REQ,-1, 1,0,0, 27);
    add(1,1,1,0,NO_REQ,0,0, c_SEL_DATA,NO_REQ,-1, 0,0,0, 26);
    add(1,1,1,0,NO_REQ,0,1, c_SEL_NONE,NO_REQ,-1, 0,1,0, 25);
    add(1,1,1,0,NO_REQ,0,0, c_SEL_INST,NO_REQ,-1, 0,0,0, 24);
    add(1,1,1,0,NO_REQ,0,1, c_SEL_NONE,NO_REQ,-1, 1,0,0, 23);
    add(1,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ,-1, 0,0,0, 22);
    // TLBWI (index 5) beats a pending inst request, then inst is served.
    add(0,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ, 0, 0,0,0, 31);
    add(1,1,0,1,TLBWI, 5,0, c_SEL_OP,  TLBWI,  5, 0,0,0, 30);
    add(1,1,0,1,TLBWI, 5,0, c_SEL_OP,  TLBWI,  5, 0,0,0, 29);
    add(1,1,0,1,TLBWI, 5,1, c_SEL_NONE,NO_REQ,-1, 0,0,1, 31);
    add(1,1,0,0,NO_REQ,5,0, c_SEL_INST,NO_REQ,-1, 0,0,0, 30);
    add(1,1,0,0,NO_REQ,0,1, c_SEL_NONE,NO_REQ,-1, 1,0,0, 29);
    add(1,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ,-1, 0,0,0, 28);
    // Data request withdrawn two cycles into the grant: no done.
    add(0,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ, 0, 0,0,0, 31);
    add(1,0,1,0,NO_REQ,0,0, c_SEL_DATA,NO_REQ,-1, 0,0,0, 30);
    add(1,0,1,0,NO_REQ,0,0, c_SEL_DATA,NO_REQ,-1, 0,0,0, 29);
    add(1,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ,-1, 0,0,0, 28);
    add(1,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ,-1, 0,0,0, 27);
    // TLBR arriving during GNT_I waits; reset during GNT_OP aborts silently.
    add(0,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ, 0, 0,0,0, 31);
    add(1,1,0,0,NO_REQ,0,0, c_SEL_INST,NO_REQ,-1, 0,0,0, 30);
    add(1,1,0,1,TLBR,  9,0, c_SEL_INST,NO_REQ,-1, 0,0,0, 29);
    add(1,1,0,1,TLBR,  9,1, c_SEL_NONE,NO_REQ,-1, 1,0,0, 28);
    add(1,0,0,1,TLBR,  9,0, c_SEL_OP,  TLBR,   9, 0,0,0, 27);
    add(1,0,0,1,TLBR,  9,0, c_SEL_OP,  TLBR,   9, 0,0,0, 26);
    add(0,0,0,1,TLBR,  9,1, c_SEL_NONE,NO_REQ, 0, 0,0,0, 31);
    add(1,0,0,0,NO_REQ,0,0, c_SEL_NONE,NO_REQ, 0, 0,0,0, 30);

    foreach (vq[i]) begin
      step(vq[i].rn, vq[i].ir, vq[i].dr, vq[i].orq, vq[i].ot, vq[i].oi, vq[i].ok);
      check($sformatf("v%0d sel", i),    32'(tlb_sel),   32'(vq[i].es));
      check($sformatf("v%0d req", i),    32'(tlb_req),   32'(vq[i].er));
      if (vq[i].ei >= 0)
        check($sformatf("v%0d index", i), 32'(tlb_index), 32'(vq[i].ei));
      check($sformatf("v%0d inst_done", i), 32'(inst_done), 32'(vq[i].eid));
      check($sformatf("v%0d data_done", i), 32'(data_done), 32'(vq[i].edd));
      check($sformatf("v%0d op_done", i),   32'(op_done),   32'(vq[i].eod));
      check($sformatf("v%0d random", i),    32'(random),    32'(vq[i].erand));
    end

    // ---------------- 40 idle cycles after reset ----------------
    idle(0);
    check("idle_rst_random", 32'(random), 32'd31);
    for (int i = 1; i <= 40; i++) begin
      idle(1);
      exp_r = (i <= 31) ? (31 - i) : (63 - i);
      check($sformatf("idle%0d random", i), 32'(random), 32'(exp_r));
      check($sformatf("idle%0d sel", i), 32'(tlb_sel), 32'(c_SEL_NONE));
      check($sformatf("idle%0d req", i), 32'(tlb_req), 32'(NO_REQ));
    end

    // ---------------- TLBWR together with data_req at random=17 ----------------
    idle(0);
    for (int i = 0; i < 14; i++) idle(1);
    check("wr_pre_random", 32'(random), 32'd17);
    step(1, 0, 1, 1, TLBWR, 5'd3, 0);
    check("wr_sel",    32'(tlb_sel),   32'(c_SEL_OP));
    check("wr_req",    32'(tlb_req),   32'(TLBWR));
    check("wr_index",  32'(tlb_index), 32'd17);
    check("wr_random", 32'(random),    32'd17);
    step(1, 0, 1, 1, TLBWR, 5'd3, 0);
    check("wr_hold_random", 32'(random), 32'd17);
    check("wr_hold_index",  32'(tlb_index), 32'd17);
    step(1, 0, 1, 1, TLBWR, 5'd3, 1);
    check("wr_op_done",    32'(op_done),   32'd1);
    check("wr_data_done",  32'(data_done), 32'd0);
    check("wr_reload",     32'(random),    32'd31);
    step(1, 0, 1, 0, NO_REQ, 5'd0, 0);
    check("wr_then_data",  32'(tlb_sel),   32'(c_SEL_DATA));
    check("wr_data_req",   32'(tlb_req),   32'(NO_REQ));
    check("wr_random2",    32'(random),    32'd30);
    step(1, 0, 1, 0, NO_REQ, 5'd0, 1);
    check("wr_data_done2", 32'(data_done), 32'd1);
    idle(1);

`ifdef TLB_WIRED_EN
    // ---------------- Wired = 8: Random cycles 31..8 ----------------
    wired = 5'd8;
    idle(0);
    check("w8_rst", 32'(random), 32'd31);
    for (int i = 1; i <= 30; i++) begin
      idle(1);
      check($sformatf("w8_%0d random", i), 32'(random), 32'(31 - (i % 24)));
    end
    // Reposition: reset, count down to 12, then raise Wired to 20.
    idle(0);
    for (int i = 0; i < 19; i++) idle(1);
    check("w20_pre", 32'(random), 32'd12);
    wired = 5'd20;
    idle(1);
    check("w20_jump", 32'(random), 32'd31);
    idle(1);
    check("w20_next", 32'(random), 32'd30);
    wired = 5'd0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
